// File: rtl/reg_mux_pkg.sv
// Shared mode encodings for the registered round-robin / fixed-select mux.
package reg_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/reg_mux_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester strictly after i_ptr wins, wrapping modulo CHANNELS.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [SEL_W-1:0]    i_ptr,
  output logic [CHANNELS-1:0] o_grant,
  output logic [SEL_W-1:0]    o_gnt_idx,
  output logic                o_gnt_any
);
  logic [CHANNELS-1:0]   w_mask;
  logic [2*CHANNELS-1:0] w_dbl;
  int                    w_pos;
  int                    w_idx;

  // The lower copy keeps only requests above ptr. The upper copy covers the wrap
  // back to channel 0, so the lowest set bit of w_dbl is the round-robin winner.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) w_mask[k] = (k > int'(i_ptr));
    w_dbl     = {i_req, i_req & w_mask};
    o_gnt_any = 1'b0;
    w_pos     = 0;
    for (int b = 0; b < 2*CHANNELS; b++) begin
      if (!o_gnt_any && w_dbl[b]) begin
        o_gnt_any = 1'b1;
        w_pos     = b;
      end
    end
    w_idx     = (w_pos >= CHANNELS) ? w_pos - CHANNELS : w_pos;
    o_gnt_idx = SEL_W'(w_idx);
    for (int k = 0; k < CHANNELS; k++) o_grant[k] = o_gnt_any && (k == w_idx);
  end
endmodule

// File: rtl/reg_mux_rr.sv
// N-channel registered mux with valid/ready flow control. It selects by a fixed index or by round-robin arbitration.
module reg_mux_rr
  import reg_mux_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       o_ready,
  input  logic                      i_mode,
  input  logic [SEL_W-1:0]          i_ctrl,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [SEL_W-1:0]          o_sel
);
  logic [WIDTH-1:0]    r_data;
  logic                r_valid;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    r_ptr;

  logic [SEL_W-1:0]    w_fix_ch;
  logic [CHANNELS-1:0] w_fix_grant;
  logic                w_fix_any;
  logic [CHANNELS-1:0] w_rr_grant;
  logic [SEL_W-1:0]    w_rr_idx;
  logic                w_rr_any;
  logic [SEL_W-1:0]    w_ch;
  logic [CHANNELS-1:0] w_grant;
  logic                w_gnt_any;
  logic                w_load_en;
  logic                w_xfer;
  logic [WIDTH-1:0]    w_sel_data;

  // Out-of-range fixed indices fall back to channel 0.
  always_comb begin
    w_fix_ch  = (int'(i_ctrl) < CHANNELS) ? i_ctrl : '0;
    w_fix_any = i_valid[w_fix_ch];
    for (int k = 0; k < CHANNELS; k++) w_fix_grant[k] = w_fix_any && (k == int'(w_fix_ch));
  end

  rr_arbiter #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_arb (
    .i_req     (i_valid),
    .i_ptr     (r_ptr),
    .o_grant   (w_rr_grant),
    .o_gnt_idx (w_rr_idx),
    .o_gnt_any (w_rr_any)
  );

  always_comb begin
    w_ch       = (i_mode == MODE_RR) ? w_rr_idx   : w_fix_ch;
    w_grant    = (i_mode == MODE_RR) ? w_rr_grant : w_fix_grant;
    w_gnt_any  = (i_mode == MODE_RR) ? w_rr_any   : w_fix_any;
    w_load_en  = !r_valid || i_ready;
    w_xfer     = w_load_en && w_gnt_any && !i_rst;
    o_ready    = w_xfer ? w_grant : '0;
    w_sel_data = i_data[w_ch*WIDTH +: WIDTH];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_ptr   <= SEL_W'(CHANNELS-1);
    end else if (w_load_en) begin
      if (w_gnt_any) begin
        r_data  <= w_sel_data;
        r_sel   <= w_ch;
        r_valid <= 1'b1;
        if (i_mode == MODE_RR) r_ptr <= w_ch;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_sel   = r_sel;
endmodule

// File: tb/tb_reg_mux_rr.sv
// Bench for reg_mux_rr: a directed vector table, a random run against a behavioural model, and a 3-channel instance.
module tb_reg_mux_rr;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mode, i_rdy;
  logic [1:0]  ctrl;
  logic [63:0] data;
  logic [3:0]  vld, o_rdy;
  logic [15:0] o_data;
  logic        o_vld;
  logic [1:0]  o_sel;

  reg_mux_rr #(.WIDTH(16), .CHANNELS(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(vld), .o_ready(o_rdy),
    .i_mode(mode), .i_ctrl(ctrl), .o_data(o_data), .o_valid(o_vld),
    .i_ready(i_rdy), .o_sel(o_sel));

  logic        rst3, mode3, i_rdy3;
  logic [1:0]  ctrl3;
  logic [23:0] data3;
  logic [2:0]  vld3, o_rdy3;
  logic [7:0]  o_data3;
  logic        o_vld3;
  logic [1:0]  o_sel3;

  reg_mux_rr #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst3), .i_data(data3), .i_valid(vld3), .o_ready(o_rdy3),
    .i_mode(mode3), .i_ctrl(ctrl3), .o_data(o_data3), .o_valid(o_vld3),
    .i_ready(i_rdy3), .o_sel(o_sel3));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       mode;
    logic [1:0] ctrl;
    logic [3:0] vld;
    logic       rdy;
    logic [3:0] e_rdy;
    logic       e_vld;
    logic [15:0] e_data;
    logic [1:0] e_sel;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, input logic m, input logic [1:0] c, input logic [3:0] v,
                              input logic rd, input logic [3:0] er, input logic ev,
                              input logic [15:0] ed, input logic [1:0] es);
    vec_t t;
    t.rst = r; t.mode = m; t.ctrl = c; t.vld = v; t.rdy = rd;
    t.e_rdy = er; t.e_vld = ev; t.e_data = ed; t.e_sel = es;
    tbl.push_back(t);
  endfunction

  // Reference model state: one output slot and the last round-robin winner.
  logic        m_vld;
  logic [15:0] m_data;
  int          m_sel, m_ptr;

  function automatic void pick(input logic md, input int c, input logic [3:0] v, input int ptr,
                               output bit g, output int ch);
    g = 0; ch = 0;
    if (md == 1'b0) begin
      ch = (c < 4) ? c : 0;
      g  = v[ch];
    end else begin
      for (int s = 1; s <= 4; s++) begin
        if (!g && v[(ptr + s) % 4]) begin
          g  = 1;
          ch = (ptr + s) % 4;
        end
      end
    end
  endfunction

  task automatic cyc3(input string nm, input logic r, input logic m, input logic [1:0] c,
                      input logic [2:0] v, input logic rd, input logic [2:0] er,
                      input logic ev, input logic [7:0] ed, input logic [1:0] es);
    rst3 = r; mode3 = m; ctrl3 = c; vld3 = v; i_rdy3 = rd;
    #1;
    chk({nm, " c3 ready"}, 32'(o_rdy3), 32'(er));
    @(posedge clk); #1;
    chk({nm, " c3 valid"}, 32'(o_vld3), 32'(ev));
    chk({nm, " c3 data"},  32'(o_data3), 32'(ed));
    chk({nm, " c3 sel"},   32'(o_sel3), 32'(es));
  endtask

  initial begin
    bit g;
    int ch;
    logic [3:0] e_rdy;
    logic       ld;

    rst = 1; mode = 0; ctrl = 0; vld = 0; i_rdy = 0;
    data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    rst3 = 1; mode3 = 0; ctrl3 = 0; vld3 = 0; i_rdy3 = 0;
    data3 = {8'hA2, 8'hA1, 8'hA0};
    @(posedge clk); #1;

    // Directed table
    add(1, 0, 0, 4'h0, 0, 4'h0, 0, 16'h0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 4'h0, 0, 4'h0, 0, 16'h0, 0);
    for (int i = 0; i < 2; i++) add(0, 0, 2, 4'hF, 1, 4'b0100, 1, 16'h1002, 2);
    add(0, 0, 2, 4'hB, 1, 4'h0, 0, 16'h1002, 2);
    for (int k = 0; k < 8; k++)
      add(0, 1, 0, 4'hF, 1, 4'(1 << (k % 4)), 1, 16'(16'h1000 + k % 4), 2'(k % 4));
    add(1, 1, 0, 4'hA, 1, 4'h0, 0, 16'h0, 0);
    add(0, 1, 0, 4'hA, 1, 4'b0010, 1, 16'h1001, 1);
    add(0, 1, 0, 4'hA, 1, 4'b1000, 1, 16'h1003, 3);
    add(0, 1, 0, 4'hA, 1, 4'b0010, 1, 16'h1001, 1);
    add(0, 1, 0, 4'hA, 1, 4'b1000, 1, 16'h1003, 3);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 4'hA, 0, 4'h0, 1, 16'h1003, 3);
    add(0, 1, 0, 4'hA, 1, 4'b0010, 1, 16'h1001, 1);
    add(0, 1, 0, 4'hF, 0, 4'h0, 1, 16'h1001, 1);
    add(1, 1, 0, 4'hF, 0, 4'h0, 0, 16'h0, 0);
    add(0, 1, 0, 4'hF, 1, 4'b0001, 1, 16'h1000, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; mode = tbl[i].mode; ctrl = tbl[i].ctrl; vld = tbl[i].vld; i_rdy = tbl[i].rdy;
      #1;
      chk($sformatf("t%0d ready", i), 32'(o_rdy), 32'(tbl[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("t%0d valid", i), 32'(o_vld), 32'(tbl[i].e_vld));
      chk($sformatf("t%0d data", i),  32'(o_data), 32'(tbl[i].e_data));
      chk($sformatf("t%0d sel", i),   32'(o_sel), 32'(tbl[i].e_sel));
    end

    // 3-channel instance: out-of-range fixed index and wrap on a non-power-of-two count
    cyc3("rst", 1, 0, 0, 3'b000, 0, 3'b000, 0, 8'h00, 0);
    cyc3("fix3", 0, 0, 3, 3'b111, 1, 3'b001, 1, 8'hA0, 0);
    cyc3("fix3nv", 0, 0, 3, 3'b110, 1, 3'b000, 0, 8'hA0, 0);
    cyc3("rr0", 0, 1, 0, 3'b111, 1, 3'b001, 1, 8'hA0, 0);
    cyc3("rr1", 0, 1, 0, 3'b111, 1, 3'b010, 1, 8'hA1, 1);
    cyc3("rr2", 0, 1, 0, 3'b111, 1, 3'b100, 1, 8'hA2, 2);
    cyc3("rr3", 0, 1, 0, 3'b111, 1, 3'b001, 1, 8'hA0, 0);

    // Random run against the model
    m_vld = 0; m_data = 0; m_sel = 0; m_ptr = 3;
    for (int i = 0; i < 600; i++) begin
      rst   = (i == 0) || ($urandom_range(0, 59) == 0);
      mode  = 1'($urandom_range(0, 1));
      ctrl  = 2'($urandom_range(0, 3));
      vld   = 4'($urandom_range(0, 15));
      i_rdy = ($urandom_range(0, 9) < 7);
      data  = {$urandom, $urandom};
      pick(mode, int'(ctrl), vld, m_ptr, g, ch);
      ld    = !m_vld || i_rdy;
      e_rdy = (!rst && ld && g) ? 4'(1 << ch) : 4'h0;
      #1;
      chk($sformatf("r%0d ready", i), 32'(o_rdy), 32'(e_rdy));
      @(posedge clk); #1;
      if (rst) begin
        m_vld = 0; m_data = 0; m_sel = 0; m_ptr = 3;
      end else if (ld) begin
        if (g) begin
          m_vld = 1; m_data = data[ch*16 +: 16]; m_sel = ch;
          if (mode) m_ptr = ch;
        end else begin
          m_vld = 0;
        end
      end
      chk($sformatf("r%0d valid", i), 32'(o_vld), 32'(m_vld));
      chk($sformatf("r%0d data", i),  32'(o_data), 32'(m_data));
      chk($sformatf("r%0d sel", i),   32'(o_sel), 32'(m_sel));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
